// File: rtl/pll_ce_gen.sv
// rtl/pll_ce_gen.sv - lock-qualified multi-channel fractional clock-enable generator
// Optional macro CEGEN_DYN_INC_EN adds runtime-writable per-channel increments.
module pll_ce_gen #(
    parameter int CHANNELS      = 2,
    parameter int ACC_W         = 24,
    parameter logic [CHANNELS*ACC_W-1:0] INC_INIT = {24'd600541, 24'd4026532},
    parameter int SETTLE_CYCLES = 1024,
    parameter int SYNC_STAGES   = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                pll_lock,
`ifdef CEGEN_DYN_INC_EN
    input  logic                inc_we,
    input  logic [2:0]          inc_sel,
    input  logic [ACC_W-1:0]    inc_data,
`endif
    output logic                ready,
    output logic [CHANNELS-1:0] ce,
    output logic [7:0]          lock_loss_cnt
);

    localparam int CNT_W = $clog2(SETTLE_CYCLES) + 1;
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        SETTLE    = 2'd1,
        RUN       = 2'd2
    } state_t;

    state_t                  state_q;
    logic [SYNC_STAGES-1:0]  sync_q;
    logic [CNT_W-1:0]        settle_cnt_q;
    logic                    ready_q;
    logic [CHANNELS-1:0]     ce_q;
    logic [7:0]              loss_cnt_q;
    logic [ACC_W-1:0]        acc_q [CHANNELS];
    logic [ACC_W-1:0]        inc_d [CHANNELS];
    logic [ACC_W:0]          sum_d [CHANNELS];
    logic                    lock_s;

    assign lock_s        = sync_q[SYNC_STAGES-1];
    assign ready         = ready_q;
    assign ce            = ce_q;
    assign lock_loss_cnt = loss_cnt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pll_lock};
        end
    end

`ifdef CEGEN_DYN_INC_EN
    logic [ACC_W-1:0] inc_q [CHANNELS];

    // Indices beyond CHANNELS match no register, so such writes fall away.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < CHANNELS; i++) begin
                inc_q[i] <= INC_INIT[i*ACC_W +: ACC_W];
            end
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (inc_we && (inc_sel == 3'(i))) begin
                    inc_q[i] <= inc_data;
                end
            end
        end
    end

    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            inc_d[i] = inc_q[i];
        end
    end
`else
    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            inc_d[i] = INC_INIT[i*ACC_W +: ACC_W];
        end
    end
`endif

    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            sum_d[i] = {1'b0, acc_q[i]} + {1'b0, inc_d[i]};
        end
    end

    // The lock_s cycle that leaves WAIT_LOCK already counts as the first settled cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= WAIT_LOCK;
            settle_cnt_q <= '0;
            ready_q      <= 1'b0;
            ce_q         <= '0;
            loss_cnt_q   <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                acc_q[i] <= '0;
            end
        end else begin
            case (state_q)
                WAIT_LOCK: begin
                    ready_q      <= 1'b0;
                    ce_q         <= '0;
                    settle_cnt_q <= '0;
                    if (lock_s) begin
                        state_q      <= SETTLE;
                        settle_cnt_q <= CNT_W'(1);
                    end
                end
                SETTLE: begin
                    ce_q <= '0;
                    if (!lock_s) begin
                        state_q      <= WAIT_LOCK;
                        settle_cnt_q <= '0;
                    end else if (settle_cnt_q == SETTLE_LAST) begin
                        state_q      <= RUN;
                        ready_q      <= 1'b1;
                        settle_cnt_q <= '0;
                    end else begin
                        settle_cnt_q <= settle_cnt_q + CNT_W'(1);
                    end
                end
                RUN: begin
                    if (!lock_s) begin
                        state_q <= WAIT_LOCK;
                        ready_q <= 1'b0;
                        ce_q    <= '0;
                        for (int i = 0; i < CHANNELS; i++) begin
                            acc_q[i] <= '0;
                        end
                        if (loss_cnt_q != 8'hFF) begin
                            loss_cnt_q <= loss_cnt_q + 8'd1;
                        end
                    end else begin
                        for (int i = 0; i < CHANNELS; i++) begin
                            acc_q[i] <= sum_d[i][ACC_W-1:0];
                            ce_q[i]  <= sum_d[i][ACC_W];
                        end
                    end
                end
                default: begin
                    state_q      <= WAIT_LOCK;
                    ready_q      <= 1'b0;
                    ce_q         <= '0;
                    settle_cnt_q <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pll_ce_gen.sv
// tb/tb_pll_ce_gen.sv - scoreboard bench for pll_ce_gen (define CEGEN_DYN_INC_EN to cover writable increments)
module tb_pll_ce_gen;

    localparam int INC0      = 128;
    localparam int INC1      = 64;
    localparam int BRING_UP  = 2 + 16;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       pll_lock = 1'b0;
    logic       ready;
    logic [1:0] ce;
    logic [7:0] lock_loss_cnt;
`ifdef CEGEN_DYN_INC_EN
    logic       inc_we = 1'b0;
    logic [2:0] inc_sel = 3'd0;
    logic [7:0] inc_data = 8'd0;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    pll_ce_gen #(
        .CHANNELS      (2),
        .ACC_W         (8),
        .INC_INIT      ({8'd64, 8'd128}),
        .SETTLE_CYCLES (16),
        .SYNC_STAGES   (2)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .pll_lock      (pll_lock),
`ifdef CEGEN_DYN_INC_EN
        .inc_we        (inc_we),
        .inc_sel       (inc_sel),
        .inc_data      (inc_data),
`endif
        .ready         (ready),
        .ce            (ce),
        .lock_loss_cnt (lock_loss_cnt)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(output int cycles, output bit saw_ce);
        cycles = 0;
        saw_ce = 1'b0;
        while (ready !== 1'b1 && cycles < 100) begin
            step();
            cycles++;
            if (ready !== 1'b1 && ce !== 2'b00) saw_ce = 1'b1;
        end
    endtask

    task automatic test_reset();
        repeat (3) step();
        n_checks++; if (ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready got=%b exp=0", ready); end
        n_checks++; if (ce !== 2'b00) begin n_fail++; $display("FAIL reset_ce got=%b exp=00", ce); end
        n_checks++; if (lock_loss_cnt !== 8'd0) begin n_fail++; $display("FAIL reset_cnt got=%0d exp=0", lock_loss_cnt); end
        reset = 1'b0;
        repeat (10) step();
        n_checks++; if (ready !== 1'b0) begin n_fail++; $display("FAIL nolock_ready got=%b exp=0", ready); end
    endtask

    task automatic test_bring_up();
        int  cyc;
        bit  sc;
        pll_lock = 1'b1;
        wait_ready(cyc, sc);
        n_checks++; if (cyc != BRING_UP) begin n_fail++; $display("FAIL bring_up_latency got=%0d exp=%0d", cyc, BRING_UP); end
        n_checks++; if (sc) begin n_fail++; $display("FAIL bring_up_ce got=1 exp=0"); end
    endtask

    task automatic test_rates();
        logic [1:0] exp_q [$];
        logic [1:0] e;
        logic [1:0] got;
        int c0 = 0;
        int c1 = 0;
        for (int k = 1; k <= 256; k++) begin
            e[0] = ((k * INC0) >> 8) != (((k - 1) * INC0) >> 8);
            e[1] = ((k * INC1) >> 8) != (((k - 1) * INC1) >> 8);
            exp_q.push_back(e);
            step();
            got = ce;
            e = exp_q.pop_front();
            n_checks++;
            if (got !== e) begin n_fail++; $display("FAIL rates_cycle%0d got=%b exp=%b", k, got, e); end
            c0 += int'(got[0]);
            c1 += int'(got[1]);
        end
        n_checks++; if (c0 != 128) begin n_fail++; $display("FAIL rates_count0 got=%0d exp=128", c0); end
        n_checks++; if (c1 != 64) begin n_fail++; $display("FAIL rates_count1 got=%0d exp=64", c1); end
    endtask

    task automatic test_lock_loss();
        int cyc;
        bit sc;
        step();
        pll_lock = 1'b0;
        step();
        step();
        n_checks++; if (ready !== 1'b1) begin n_fail++; $display("FAIL loss_early_ready got=%b exp=1", ready); end
        step();
        n_checks++; if (ready !== 1'b0) begin n_fail++; $display("FAIL loss_ready got=%b exp=0", ready); end
        n_checks++; if (ce !== 2'b00) begin n_fail++; $display("FAIL loss_ce got=%b exp=00", ce); end
        n_checks++; if (lock_loss_cnt !== 8'd1) begin n_fail++; $display("FAIL loss_cnt1 got=%0d exp=1", lock_loss_cnt); end
        pll_lock = 1'b1;
        wait_ready(cyc, sc);
        n_checks++; if (cyc != BRING_UP) begin n_fail++; $display("FAIL relock_latency got=%0d exp=%0d", cyc, BRING_UP); end
        step();
        n_checks++; if (ce !== 2'b00) begin n_fail++; $display("FAIL acc_clear_c1 got=%b exp=00", ce); end
        step();
        n_checks++; if (ce !== 2'b01) begin n_fail++; $display("FAIL acc_clear_c2 got=%b exp=01", ce); end
        for (int d = 0; d < 299; d++) begin
            pll_lock = 1'b0;
            repeat (3) step();
            pll_lock = 1'b1;
            wait_ready(cyc, sc);
        end
        n_checks++; if (lock_loss_cnt !== 8'd255) begin n_fail++; $display("FAIL loss_saturate got=%0d exp=255", lock_loss_cnt); end
        n_checks++; if (ready !== 1'b1) begin n_fail++; $display("FAIL loss_loop_ready got=%b exp=1", ready); end
    endtask

    task automatic test_glitch();
        int cyc;
        bit sc;
        pll_lock = 1'b0;
        repeat (4) step();
        pll_lock = 1'b1;
        repeat (10) step();
        pll_lock = 1'b0;
        repeat (4) step();
        n_checks++; if (ready !== 1'b0) begin n_fail++; $display("FAIL glitch_ready got=%b exp=0", ready); end
        pll_lock = 1'b1;
        wait_ready(cyc, sc);
        n_checks++; if (cyc != BRING_UP) begin n_fail++; $display("FAIL glitch_latency got=%0d exp=%0d", cyc, BRING_UP); end
        n_checks++; if (sc) begin n_fail++; $display("FAIL glitch_ce got=1 exp=0"); end
        n_checks++; if (lock_loss_cnt !== 8'd255) begin n_fail++; $display("FAIL glitch_cnt got=%0d exp=255", lock_loss_cnt); end
    endtask

    task automatic test_async_reset();
        int cyc;
        bit sc;
        int n = 0;
        while (ce[0] !== 1'b1 && n < 8) begin
            step();
            n++;
        end
        n_checks++; if (ce[0] !== 1'b1) begin n_fail++; $display("FAIL areset_pre_ce got=%b exp=1", ce[0]); end
        #2 reset = 1'b1;
        #1;
        n_checks++; if (ready !== 1'b0) begin n_fail++; $display("FAIL areset_ready got=%b exp=0", ready); end
        n_checks++; if (ce !== 2'b00) begin n_fail++; $display("FAIL areset_ce got=%b exp=00", ce); end
        n_checks++; if (lock_loss_cnt !== 8'd0) begin n_fail++; $display("FAIL areset_cnt got=%0d exp=0", lock_loss_cnt); end
        #1 reset = 1'b0;
        wait_ready(cyc, sc);
        n_checks++; if (cyc != BRING_UP) begin n_fail++; $display("FAIL areset_latency got=%0d exp=%0d", cyc, BRING_UP); end
        n_checks++; if (sc) begin n_fail++; $display("FAIL areset_ce_before_ready got=1 exp=0"); end
    endtask

`ifdef CEGEN_DYN_INC_EN
    task automatic test_dyn_inc();
        int c0;
        int c1;
        inc_sel = 3'd5; inc_data = 8'd0; inc_we = 1'b1;
        step();
        inc_we = 1'b0;
        step();
        c0 = 0; c1 = 0;
        for (int k = 0; k < 64; k++) begin
            step();
            c0 += int'(ce[0]);
            c1 += int'(ce[1]);
        end
        n_checks++; if (c0 != 32) begin n_fail++; $display("FAIL dyn_sel5_ch0 got=%0d exp=32", c0); end
        n_checks++; if (c1 != 16) begin n_fail++; $display("FAIL dyn_sel5_ch1 got=%0d exp=16", c1); end
        inc_sel = 3'd1; inc_data = 8'd0; inc_we = 1'b1;
        step();
        inc_we = 1'b0;
        step();
        c0 = 0; c1 = 0;
        for (int k = 0; k < 64; k++) begin
            step();
            c0 += int'(ce[0]);
            c1 += int'(ce[1]);
        end
        n_checks++; if (c0 != 32) begin n_fail++; $display("FAIL dyn_sel1_ch0 got=%0d exp=32", c0); end
        n_checks++; if (c1 != 0) begin n_fail++; $display("FAIL dyn_sel1_ch1 got=%0d exp=0", c1); end
    endtask
`endif

    initial begin
        test_reset();
        test_bring_up();
        test_rates();
        test_lock_loss();
        test_glitch();
        test_async_reset();
`ifdef CEGEN_DYN_INC_EN
        test_dyn_inc();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
